// File: rtl/cache_pkg.sv
// Shared cache constants and the line-mask encoder state type.
package cache_pkg;

    localparam int CACHE_LINES = 64;
    localparam int LINE_IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } lme_state_t;

endpackage

// File: rtl/lowest_set_enc.sv
// Combinational priority encoder: index of the lowest set bit of mask_i.
module lowest_set_enc #(
    parameter int N     = 64,
    parameter int IDX_W = 6
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_o = '0;
        any_o   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                index_o = IDX_W'(i);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_mask_encoder.sv
// Walks a cache-line mask and streams the set line indices, lowest first,
// one per accepted valid/ready handshake.
module line_mask_encoder
    import cache_pkg::*;
#(
    parameter int N     = CACHE_LINES,
    parameter int IDX_W = LINE_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     mask_in,
    input  logic             abort,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             busy,
    output logic             done,
    output logic             load_err,
    output logic [IDX_W:0]   count,
    output lme_state_t       state_dbg
);

    // Handshake: an index transfers on any rising edge where idx_valid and
    // idx_ready are both high; idx_valid is held until that happens or an abort.

    lme_state_t       state_q, state_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             load_err_q, load_err_d;

    logic [N-1:0]     enc_in;
    logic [N-1:0]     enc_rest;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             hs;

    // One encoder serves both the initial load and every later step.
    assign enc_in   = (state_q == IDLE) ? mask_in : rem_q;
    assign enc_rest = enc_in & (enc_in - N'(1));
    assign hs       = (state_q == EMIT) && idx_ready;

    lowest_set_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .mask_i  (enc_in),
        .index_o (enc_idx),
        .any_o   (enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = enc_any ? EMIT : FIN;
                end
            end
            EMIT: begin
                if (abort || (hs && !enc_any)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d      = rem_q;
        idx_d      = idx_q;
        count_d    = count_q;
        load_err_d = load && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (load) begin
                    count_d = '0;
                    if (enc_any) begin
                        idx_d = enc_idx;
                        rem_d = enc_rest;
                    end
                end
            end
            EMIT: begin
                if (hs) begin
                    count_d = count_q + (IDX_W + 1)'(1);
                end
                if (abort) begin
                    rem_d = '0;
                end else if (hs && enc_any) begin
                    idx_d = enc_idx;
                    rem_d = enc_rest;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        idx_valid = (state_q == EMIT);
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        idx_out   = idx_q;
        count     = count_q;
        load_err  = load_err_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_line_mask_encoder.sv
// Directed bench for line_mask_encoder: table of walk vectors plus
// hand-written stall, abort/load-error and mid-walk reset sequences.
module tb_line_mask_encoder;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [63:0] mask_in = '0;
    logic        abort = 1'b0;
    logic [5:0]  idx_out;
    logic        idx_valid;
    logic        idx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        load_err;
    logic [6:0]  count;
    lme_state_t  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q[$];

    typedef struct {
        logic [63:0] mask;
        int          exp_count;
        int          exp_first;
        int          exp_last;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    line_mask_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mask_in   (mask_in),
        .abort     (abort),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .busy      (busy),
        .done      (done),
        .load_err  (load_err),
        .count     (count),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_idx_out",   64'(idx_out),   64'd0);
        check("rst_idx_valid", 64'(idx_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_load_err",  64'(load_err),  64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_state",     64'(state_dbg), 64'(IDLE));
    endtask

    task automatic run_walk(input vec_t v);
        int cyc;
        int n_valid;
        int first_idx;
        int last_idx;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            if (v.mask[i]) exp_q.push_back(6'(i));
        end
        first_idx = -1;
        last_idx  = -1;
        n_valid   = 0;
        load      = 1'b1;
        mask_in   = v.mask;
        idx_ready = 1'b1;
        tick();
        load = 1'b0;
        cyc  = 1;
        while (!done && cyc < 200) begin
            if (idx_valid) begin
                n_valid++;
                if (first_idx < 0) first_idx = int'(idx_out);
                last_idx = int'(idx_out);
                if (exp_q.size() == 0) begin
                    check("walk_extra_index", 64'(idx_out), 64'hFFFF);
                end else begin
                    check("walk_index", 64'(idx_out), 64'(exp_q.pop_front()));
                end
            end
            tick();
            cyc++;
        end
        check("walk_done_seen", 64'(done), 64'd1);
        check("walk_latency", 64'(cyc), 64'(v.exp_lat));
        check("walk_valid_cycles", 64'(n_valid), 64'(v.exp_count));
        check("walk_queue_empty", 64'(exp_q.size()), 64'd0);
        check("walk_count", 64'(count), 64'(v.exp_count));
        check("walk_fin_busy", 64'(busy), 64'd1);
        check("walk_fin_valid", 64'(idx_valid), 64'd0);
        if (v.exp_count > 0) begin
            check("walk_first", 64'(first_idx), 64'(v.exp_first));
            check("walk_last", 64'(last_idx), 64'(v.exp_last));
        end
        tick();
        check("walk_idle_busy", 64'(busy), 64'd0);
        check("walk_idle_done", 64'(done), 64'd0);
        check("walk_idle_count", 64'(count), 64'(v.exp_count));
        idx_ready = 1'b0;
    endtask

    initial begin
        int ptr;
        int p;
        int cyc;
        logic [5:0] stall_exp[4];
        logic       ready_pat[4];
        vec_t       v_all;

        vecs[0] = '{64'h8000_0000_0000_0011, 3, 0, 63, 4};
        vecs[1] = '{64'h0,                   0, 0, 0,  1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 63, 65};
        vecs[3] = '{64'h1,                   1, 0, 0,  2};
        vecs[4] = '{64'h8000_0000_0000_0000, 1, 63, 63, 2};
        vecs[5] = '{64'hA5,                  4, 0, 7,  5};
        vecs[6] = '{64'h0000_0001_0000_0000, 1, 32, 32, 2};

        tick(); tick(); tick();
        rst = 1'b0;
        check_reset_values();

        // Abort while idle must be ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_done", 64'(done), 64'd0);

        foreach (vecs[i]) run_walk(vecs[i]);

        // Stall sequence: ready pattern 1,0,0,1 on mask 0x0F00.
        stall_exp[0] = 6'd8;  stall_exp[1] = 6'd9;
        stall_exp[2] = 6'd10; stall_exp[3] = 6'd11;
        ready_pat[0] = 1'b1; ready_pat[1] = 1'b0;
        ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;
        load    = 1'b1;
        mask_in = 64'h0000_0000_0000_0F00;
        tick();
        load = 1'b0;
        ptr  = 0;
        p    = 0;
        cyc  = 1;
        while (!done && cyc < 100) begin
            if (idx_valid) begin
                check("stall_idx", 64'(idx_out), 64'(stall_exp[ptr % 4]));
                idx_ready = ready_pat[p % 4];
                p++;
            end
            tick();
            if (idx_ready) ptr++;
            cyc++;
        end
        idx_ready = 1'b0;
        check("stall_accepted", 64'(ptr), 64'd4);
        check("stall_latency", 64'(cyc), 64'd9);
        check("stall_count", 64'(count), 64'd4);
        tick();

        // Load during EMIT, then abort on the second handshake, then load during FIN.
        load      = 1'b1;
        mask_in   = 64'hF0;
        idx_ready = 1'b1;
        tick();
        check("ab_first_idx", 64'(idx_out), 64'd4);
        mask_in = 64'h3;
        tick();
        load = 1'b0;
        check("ab_load_err", 64'(load_err), 64'd1);
        check("ab_second_idx", 64'(idx_out), 64'd5);
        check("ab_count1", 64'(count), 64'd1);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        idx_ready = 1'b0;
        check("ab_done", 64'(done), 64'd1);
        check("ab_valid_drop", 64'(idx_valid), 64'd0);
        check("ab_count2", 64'(count), 64'd2);
        check("ab_load_err_clr", 64'(load_err), 64'd0);
        load    = 1'b1;
        mask_in = 64'h1;
        tick();
        load = 1'b0;
        check("fin_load_err", 64'(load_err), 64'd1);
        check("fin_load_ignored", 64'(busy), 64'd0);
        check("fin_count_hold", 64'(count), 64'd2);
        tick();
        check("fin_load_err_clr", 64'(load_err), 64'd0);
        check("fin_still_idle", 64'(busy), 64'd0);

        // Reset mid-walk after five accepted indices.
        load      = 1'b1;
        mask_in   = 64'hFFFF_FFFF_FFFF_FFFF;
        idx_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("mid_idx_before_rst", 64'(idx_out), 64'd5);
        check("mid_count_before_rst", 64'(count), 64'd5);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        idx_ready = 1'b0;
        check_reset_values();
        v_all = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 63, 65};
        run_walk(v_all);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
